// File: rtl/rvfpm_issue_queue.sv
// In-order issue buffer between the XIF offload interface and the rvfpm FPU model.
// Entries wait for commit/kill; committed ones dispatch in order, killed ones drain silently.
module rvfpm_issue_queue #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                         ck,
    input  logic                         rst,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [INSTR_WIDTH-1:0]       issue_instr,
    input  logic [X_ID_WIDTH-1:0]        issue_id,
    input  logic                         commit_valid,
    input  logic [X_ID_WIDTH-1:0]        commit_id,
    input  logic                         commit_kill,
    input  logic                         flush,
    input  logic                         fpu_ready,
    output logic                         enable,
    output logic [INSTR_WIDTH-1:0]       instruction,
    output logic [X_ID_WIDTH-1:0]        id,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         commit_miss
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_q    [DEPTH];
    logic [DEPTH-1:0]       cmt_q;
    logic [DEPTH-1:0]       kil_q;
    logic [PW-1:0]          rd_q;
    logic [PW-1:0]          wr_q;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic                   enable_q;
    logic [INSTR_WIDTH-1:0] instruction_q;
    logic [X_ID_WIDTH-1:0]  id_out_q;
    logic                   miss_q;

    logic          accept;
    logic          pop;
    logic          dispatch;
    logic          found;
    logic [PW-1:0] hit_idx;
    logic [PW-1:0] scan_idx;
    logic          new_hit;
    logic          miss;

    assign issue_ready = (count_q < CW'(DEPTH));
    assign accept      = issue_valid && issue_ready;

    // Oldest stored, uncommitted entry carrying commit_id; scan starts at the head.
    always_comb begin
        found    = 1'b0;
        hit_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_q + PW'(i);
            if (!found && commit_valid && (CW'(i) < count_q) && !cmt_q[scan_idx] &&
                (id_q[scan_idx] == commit_id)) begin
                found   = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

    assign new_hit  = commit_valid && !found && accept && (issue_id == commit_id);
    assign miss     = commit_valid && !found && !new_hit;
    assign pop      = (count_q != '0) && cmt_q[rd_q] && (kil_q[rd_q] || fpu_ready);
    assign dispatch = pop && !kil_q[rd_q];
    assign count_d  = count_q + CW'(accept) - CW'(pop);

    always_ff @(posedge ck) begin
        if (accept && !rst && !flush) begin
            instr_q[wr_q] <= issue_instr;
            id_q[wr_q]    <= issue_id;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            rd_q          <= '0;
            wr_q          <= '0;
            count_q       <= '0;
            cmt_q         <= '0;
            kil_q         <= '0;
            enable_q      <= 1'b0;
            instruction_q <= '0;
            id_out_q      <= '0;
            miss_q        <= 1'b0;
        end else if (flush) begin
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
            cmt_q    <= '0;
            kil_q    <= '0;
            enable_q <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            // Head is committed when popped and a hit is uncommitted, so these never collide.
            if (pop) begin
                cmt_q[rd_q] <= 1'b0;
                kil_q[rd_q] <= 1'b0;
                rd_q        <= rd_q + PW'(1);
            end
            if (accept) begin
                cmt_q[wr_q] <= new_hit;
                kil_q[wr_q] <= new_hit && commit_kill;
                wr_q        <= wr_q + PW'(1);
            end
            if (found) begin
                cmt_q[hit_idx] <= 1'b1;
                kil_q[hit_idx] <= commit_kill;
            end
            count_q  <= count_d;
            enable_q <= dispatch;
            miss_q   <= miss;
            if (dispatch) begin
                instruction_q <= instr_q[rd_q];
                id_out_q      <= id_q[rd_q];
            end
        end
    end

    assign enable      = enable_q;
    assign instruction = instruction_q;
    assign id          = id_out_q;
    assign count       = count_q;
    assign commit_miss = miss_q;

endmodule

// File: tb/tb_rvfpm_issue_queue.sv
// Directed bench for rvfpm_issue_queue; inputs driven and outputs sampled 1ns after each posedge.
module tb_rvfpm_issue_queue;

    logic        ck = 1'b0;
    logic        rst, issue_valid, issue_ready, commit_valid, commit_kill, flush, fpu_ready;
    logic [31:0] issue_instr, instruction;
    logic [3:0]  issue_id, commit_id, id;
    logic        enable, commit_miss;
    logic [2:0]  count;

    int n_pass = 0;
    int n_total = 0;

    rvfpm_issue_queue dut (
        .ck(ck), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instr(issue_instr), .issue_id(issue_id), .commit_valid(commit_valid),
        .commit_id(commit_id), .commit_kill(commit_kill), .flush(flush),
        .fpu_ready(fpu_ready), .enable(enable), .instruction(instruction), .id(id),
        .count(count), .commit_miss(commit_miss)
    );

    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; commit_valid = 0; commit_kill = 0; flush = 0; rst = 0;
    endtask

    task automatic issue(input logic [3:0] i, input logic [31:0] w);
        issue_valid = 1; issue_id = i; issue_instr = w;
        tick();
        issue_valid = 0;
    endtask

    task automatic commit(input logic [3:0] i, input logic k);
        commit_valid = 1; commit_id = i; commit_kill = k;
        tick();
        commit_valid = 0; commit_kill = 0;
    endtask

    task automatic test_reset();
        idle(); fpu_ready = 0; issue_instr = 0; issue_id = 0; commit_id = 0;
        rst = 1; tick(); tick(); rst = 0;
        n_total++;
        if (count !== 3'd0 || issue_ready !== 1'b1 || enable !== 1'b0 || commit_miss !== 1'b0)
            $display("FAIL reset: count=%0d ready=%b en=%b miss=%b, want 0/1/0/0",
                     count, issue_ready, enable, commit_miss);
        else n_pass++;
        n_total++;
        if (instruction !== 32'h0 || id !== 4'h0)
            $display("FAIL reset_out: instr=%h id=%h, want 0/0", instruction, id);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        fpu_ready = 1;
        issue_valid = 1; issue_id = 3; issue_instr = 32'h0000_1053;
        commit_valid = 1; commit_id = 3; commit_kill = 0;
        tick(); idle();
        n_total++;
        if (enable !== 1'b0 || count !== 3'd1)
            $display("FAIL same_c1: en=%b count=%0d, want 0/1", enable, count);
        else n_pass++;
        tick();
        n_total++;
        if (enable !== 1'b1 || instruction !== 32'h0000_1053 || id !== 4'd3 || count !== 3'd0)
            $display("FAIL same_c2: en=%b instr=%h id=%0d count=%0d, want 1/00001053/3/0",
                     enable, instruction, id, count);
        else n_pass++;
        tick();
        n_total++;
        if (enable !== 1'b0 || instruction !== 32'h0000_1053)
            $display("FAIL same_c3: en=%b instr=%h, want 0 and held", enable, instruction);
        else n_pass++;
    endtask

    task automatic test_full();
        fpu_ready = 0;
        for (int i = 0; i < 4; i++) issue(4'(i), 32'h100 + i);
        n_total++;
        if (count !== 3'd4 || issue_ready !== 1'b0)
            $display("FAIL full: count=%0d ready=%b, want 4/0", count, issue_ready);
        else n_pass++;
        issue(4'd7, 32'hdead);
        n_total++;
        if (count !== 3'd4) $display("FAIL full_reject: count=%0d, want 4", count);
        else n_pass++;
        fpu_ready = 1;
        commit(4'd0, 0);
        tick();
        n_total++;
        if (count !== 3'd3 || issue_ready !== 1'b1 || enable !== 1'b1 || id !== 4'd0 ||
            instruction !== 32'h100)
            $display("FAIL full_pop: count=%0d ready=%b en=%b id=%0d instr=%h, want 3/1/1/0/100",
                     count, issue_ready, enable, id, instruction);
        else n_pass++;
        flush = 1; tick(); flush = 0;
        n_total++;
        if (count !== 3'd0) $display("FAIL full_flush: count=%0d, want 0", count);
        else n_pass++;
    endtask

    task automatic test_order();
        int early_en = 0;
        fpu_ready = 1;
        issue(4'd5, 32'ha5);
        issue(4'd6, 32'ha6);
        commit(4'd6, 0);
        if (enable) early_en++;
        tick(); if (enable) early_en++;
        tick(); if (enable) early_en++;
        commit(4'd5, 0);
        if (enable) early_en++;
        n_total++;
        if (early_en != 0) $display("FAIL order_wait: early enables=%0d, want 0", early_en);
        else n_pass++;
        tick();
        n_total++;
        if (enable !== 1'b1 || id !== 4'd5 || instruction !== 32'ha5)
            $display("FAIL order_first: en=%b id=%0d instr=%h, want 1/5/a5", enable, id, instruction);
        else n_pass++;
        tick();
        n_total++;
        if (enable !== 1'b1 || id !== 4'd6 || instruction !== 32'ha6)
            $display("FAIL order_second: en=%b id=%0d instr=%h, want 1/6/a6", enable, id, instruction);
        else n_pass++;
        tick();
        n_total++;
        if (enable !== 1'b0 || count !== 3'd0)
            $display("FAIL order_end: en=%b count=%0d, want 0/0", enable, count);
        else n_pass++;
    endtask

    task automatic test_kill();
        fpu_ready = 0;
        issue(4'd1, 32'hb1); issue(4'd2, 32'hb2); issue(4'd3, 32'hb3);
        commit(4'd1, 1);
        n_total++;
        if (count !== 3'd3) $display("FAIL kill_a: count=%0d, want 3", count);
        else n_pass++;
        commit(4'd2, 1);
        n_total++;
        if (count !== 3'd2 || enable !== 1'b0)
            $display("FAIL kill_b: count=%0d en=%b, want 2/0", count, enable);
        else n_pass++;
        commit(4'd3, 0);
        n_total++;
        if (count !== 3'd1 || enable !== 1'b0)
            $display("FAIL kill_c: count=%0d en=%b, want 1/0", count, enable);
        else n_pass++;
        tick();
        n_total++;
        if (count !== 3'd1 || enable !== 1'b0)
            $display("FAIL kill_hold: count=%0d en=%b, want 1/0", count, enable);
        else n_pass++;
        fpu_ready = 1;
        tick();
        fpu_ready = 0;
        n_total++;
        if (enable !== 1'b1 || id !== 4'd3 || instruction !== 32'hb3 || count !== 3'd0)
            $display("FAIL kill_disp: en=%b id=%0d instr=%h count=%0d, want 1/3/b3/0",
                     enable, id, instruction, count);
        else n_pass++;
        tick();
    endtask

    task automatic test_miss();
        commit(4'd9, 0);
        n_total++;
        if (commit_miss !== 1'b1 || count !== 3'd0)
            $display("FAIL miss_pulse: miss=%b count=%0d, want 1/0", commit_miss, count);
        else n_pass++;
        tick();
        n_total++;
        if (commit_miss !== 1'b0) $display("FAIL miss_clear: miss=%b, want 0", commit_miss);
        else n_pass++;
    endtask

    task automatic fill_committed();
        fpu_ready = 0;
        for (int i = 1; i <= 3; i++) begin
            issue_valid = 1; issue_id = 4'(i); issue_instr = 32'hc0 + i;
            commit_valid = 1; commit_id = 4'(i); commit_kill = 0;
            tick();
        end
        idle();
    endtask

    task automatic test_flush_rst();
        for (int pass = 0; pass < 2; pass++) begin
            fill_committed();
            n_total++;
            if (count !== 3'd3) $display("FAIL discard_fill%0d: count=%0d, want 3", pass, count);
            else n_pass++;
            if (pass == 0) begin
                flush = 1; commit_valid = 1; commit_id = 9;
            end else begin
                rst = 1;
            end
            tick(); idle();
            n_total++;
            if (count !== 3'd0 || issue_ready !== 1'b1 || enable !== 1'b0 || commit_miss !== 1'b0)
                $display("FAIL discard%0d: count=%0d ready=%b en=%b miss=%b, want 0/1/0/0",
                         pass, count, issue_ready, enable, commit_miss);
            else n_pass++;
            fpu_ready = 1;
            tick(); tick();
            n_total++;
            if (enable !== 1'b0 || count !== 3'd0)
                $display("FAIL discard_after%0d: en=%b count=%0d, want 0/0", pass, enable, count);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_full();
        test_order();
        test_kill();
        test_miss();
        test_flush_rst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rvfpm_issue_queue.md
Name: rvfpm_issue_queue

Overview:
- Issue-side buffer directly upstream of the rvfpm FPU model.
- Accepts CORE-V-XIF offloaded instructions with IDs and holds them until the core commits or kills each one.
- Dispatches committed instructions in order to the FPU when fpu_ready is high, using a one-cycle enable pulse with instruction and id.
- Drops killed instructions silently.

Parameters:
- X_ID_WIDTH, 4, width of the XIF instruction ID.
- DEPTH, 4, number of queue entries; power of two, at least 2.
- INSTR_WIDTH, 32, instruction word width.

Ports:
- ck  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- issue_valid  input  1  core offers an instruction.
- issue_ready  output  1  queue can accept.
- issue_instr  input  INSTR_WIDTH  instruction word.
- issue_id  input  X_ID_WIDTH  XIF ID of the offered instruction.
- commit_valid  input  1  commit or kill strobe.
- commit_id  input  X_ID_WIDTH  ID being committed or killed.
- commit_kill  input  1  1 = kill, 0 = commit.
- flush  input  1  discard all entries.
- fpu_ready  input  1  FPU can take an instruction this cycle.
- enable  output  1  one-cycle dispatch pulse to the FPU.
- instruction  output  INSTR_WIDTH  dispatched instruction word.
- id  output  X_ID_WIDTH  ID of the dispatched instruction.
- count  output  $clog2(DEPTH+1)  number of occupied entries.
- commit_miss  output  1  pulse: commit_valid matched no outstanding uncommitted entry.

Behaviour:
- Clock and reset: one clock, ck. Reset rst is synchronous and active-high.
  - While rst is high at a posedge: pointers, count, and all entry valid/committed/killed flags clear.
  - enable, instruction, id, and commit_miss go to 0. issue_ready is therefore 1 after reset.
  - Reset mid-operation discards every entry with no dispatch.
- Storage: circular buffer with wr_ptr and rd_ptr of width $clog2(DEPTH). Pointers wrap from DEPTH-1 to 0. Each entry holds instr, id, committed flag, and killed flag.
- Issue:
  - issue_ready = (count < DEPTH), decoded from registered state only.
  - An entry is accepted at the posedge where issue_valid && issue_ready.
  - No accept when full, even if a pop happens in the same cycle.
- Commit/kill, applied at the posedge where commit_valid is high:
  - Targets the oldest valid, uncommitted entry whose id == commit_id.
  - Sets committed=1, and also killed=1 if commit_kill is high.
  - If the entry being written in the same cycle carries the same id and no stored entry matches, the commit applies to the new entry as it is written.
  - No match: state is unchanged and commit_miss is 1 in the next cycle only.
- Pop decision each cycle on the head entry (rd_ptr, count>0):
  - Head committed and killed: pop with no dispatch, regardless of fpu_ready. Disposal rate is one killed entry per cycle.
  - Head committed, not killed, and fpu_ready=1: pop and dispatch.
  - Otherwise, or if the head is uncommitted: hold.
- Dispatch outputs are registered:
  - On a dispatching posedge, enable=1 and instruction and id are loaded from the head.
  - Otherwise enable=0 and instruction and id hold their last values.
  - enable is never high for two consecutive cycles for the same entry.
- Latency:
  - If issue and commit are both in cycle 0 and fpu_ready is high, enable is high in cycle 2.
  - A commit arriving later than that gives dispatch 2 cycles after the commit cycle.
- Ordering: dispatch is strictly in issue order. A committed younger entry waits behind an uncommitted head.
- count:
  - Next count = count + accept − pop. Simultaneous accept and pop leaves count unchanged.
  - Max DEPTH, min 0. It never over- or underflows.
- flush:
  - The queue is cleared at the next posedge (pointers 0, count 0, flags cleared).
  - Priority is over issue, commit, and pop. enable=0 in the following cycle.
  - commit_miss is not raised on a flush cycle.
- Priority: rst > flush > {accept, commit, pop}. The last three act concurrently in the same cycle.

Test Plan:
- Reset, then issue id=3 with instr=0x0000_1053 and commit_valid/commit_id=3/kill=0 in the same cycle, fpu_ready=1.
  - enable high exactly 2 cycles later, instruction=0x0000_1053, id=3, count returns to 0.
- Fill with ids 0,1,2,3 (DEPTH=4) and no commits.
  - count=4, issue_ready=0; a 5th issue_valid is not accepted.
  - Commit id 0 with fpu_ready=1: one pop, issue_ready=1 the next cycle.
- Issue ids 5,6; commit 6 first, then 5 three cycles later.
  - No enable until after the commit of 5.
  - Dispatches come out in order id 5 then id 6 on consecutive enable pulses.
- Issue ids 1,2,3; kill 1 and 2, commit 3, fpu_ready=0 throughout.
  - count drops 3→2→1 over two cycles with enable=0.
  - id 3 dispatches one cycle after fpu_ready rises.
- commit_valid with id 9, nothing outstanding: commit_miss=1 for exactly one cycle and count unchanged.
- Queue holding 3 committed entries with fpu_ready=0, assert flush, and separately rst mid-stream.
  - Both cases: count=0 next cycle, issue_ready=1, and no enable pulse for the discarded entries.
